snake_input_feeder: RTL

Upstream stage of chip: fetches input-feature-map pixels from an external frame memory and streams them into chip.data_in in the serpentine order the conv PE array consumes. Phase HEAD interleaves rows 0/1 column by column; phase BODY walks rows 2..ROW-1, even rows right-to-left, odd rows left-to-right. Replaces the behavioural DRAM model in the chip bench and is the synthesizable feeder in front of chip.

---
 rtl/snake_input_feeder_if.sv | 41 ++++
 rtl/snake_input_feeder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/snake_input_feeder_if.sv
// Handshake/bus bundle between the serpentine pixel feeder, its frame memory
// and the consuming chip; master = feeder side, slave = memory/chip side.
interface snake_input_feeder_if #(
    parameter int CH     = 3,
    parameter int OUT_W  = 256,
    parameter int ADDR_W = 14
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [CH*8-1:0]   mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/snake_input_feeder.sv
// Streams one frame from frame memory in serpentine order through a 2-entry FIFO.
// Optional SNAKE_ZERO_PAD_EN adds a 1-pixel zero border that is never read from memory.
module snake_input_feeder #(
    parameter int ROW    = 128,
    parameter int COL    = 128,
    parameter int CH     = 3,
    parameter int OUT_W  = 256,
    parameter int ADDR_W = 14
) (
    input  logic clk,
    input  logic rst,
    snake_input_feeder_if.master bus
);
    localparam int PX_W = CH * 8;
`ifdef SNAKE_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int PR = ROW + 2 * PAD;
    localparam int PC = COL + 2 * PAD;
    localparam int RW = $clog2(PR);
    localparam int CW = (PC > 1) ? $clog2(PC) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(PR - 1);
    localparam logic [RW-1:0] PAD_R    = RW'(PAD);
    localparam logic [CW-1:0] COL_LAST = CW'(PC - 1);
    localparam logic [CW-1:0] PAD_C    = CW'(PAD);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              sub_q, sub_d;
    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;
    logic              zero_q, zero_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PX_W-1:0]   head_q, head_d;
    logic [PX_W-1:0]   tail_q, tail_d;

    logic              out_valid, pop, issue, border, rd_en;
    logic [1:0]        used;
    logic [RW-1:0]     cur_r;
    logic [ADDR_W-1:0] addr_calc;
    logic [PX_W-1:0]   push_data;

    // A beat accepted this cycle frees its slot in time for a new issue.
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && bus.out_ready;
    assign used      = count_q + {1'b0, inflight_q};
    assign issue     = ((state_q == S_HEAD) || (state_q == S_BODY)) &&
                       ((used - {1'b0, pop}) < 2'd2);
    assign cur_r     = (state_q == S_HEAD) ? RW'(sub_q) : row_q;

`ifdef SNAKE_ZERO_PAD_EN
    assign border = (cur_r == '0) || (cur_r == ROW_LAST) ||
                    (col_q == '0) || (col_q == COL_LAST);
`else
    assign border = 1'b0;
`endif

    assign rd_en     = issue && !border;
    assign addr_calc = ADDR_W'(cur_r - PAD_R) * ADDR_W'(COL) + ADDR_W'(col_q - PAD_C);
    assign push_data = zero_q ? '0 : bus.mem_rdata;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        sub_d   = sub_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_HEAD;
                    col_d   = '0;
                    row_d   = '0;
                    sub_d   = 1'b0;
                end
            end
            S_HEAD: begin
                if (issue) begin
                    sub_d = !sub_q;
                    if (sub_q) begin
                        if (col_q == COL_LAST) begin
                            // Row 2 is even and walks right-to-left, so col stays at the right edge.
                            if (PR == 2) begin
                                state_d = S_DRAIN;
                            end else begin
                                state_d = S_BODY;
                                row_d   = RW'(2);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            S_BODY: begin
                if (issue) begin
                    if ((!row_q[0] && col_q == '0) || (row_q[0] && col_q == COL_LAST)) begin
                        if (row_q == ROW_LAST) state_d = S_DRAIN;
                        else                   row_d   = row_q + RW'(1);
                    end else if (!row_q[0]) begin
                        col_d = col_q - CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = rd_en ? addr_calc : addr_q;
        inflight_d = issue;
        zero_d     = issue && border;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end
        if (inflight_q) begin
            if (count_d == 2'd0) head_d = push_data;
            else                 tail_d = push_data;
            count_d = count_d + 2'd1;
        end
    end

    // NOTE: the two FIFO entries are reset too, so out_data reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            sub_q      <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            zero_q     <= 1'b0;
            addr_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            sub_q      <= sub_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            zero_q     <= zero_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = addr_d;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = OUT_W'(head_q);
endmodule
